// File: rtl/wpa2_pio_bridge.sv
// wpa2_pio_bridge: PIO-strobe register bridge that feeds 512-bit blocks to a SHA-1 engine and captures its digest
module wpa2_pio_bridge #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic [ADDR_W-1:0] pio_addr,
    input  logic [DATA_W-1:0] pio_wdata,
    output logic [DATA_W-1:0] pio_rdata,
    input  logic [3:0]        pio_ctrl_in,
    output logic [3:0]        pio_ctrl_out,
    output logic              blk_valid,
    input  logic              blk_ready,
    output logic              blk_last,
    output logic [511:0]      blk_data,
    input  logic              dig_valid,
    input  logic [159:0]      dig_data
);
    typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_t;
    state_t                  state_q, state_d;
    logic [3:0]              ctrl_q, prev_q, rise;
    logic [15:0][DATA_W-1:0] msg_q, msg_d;
    logic [4:0][DATA_W-1:0]  dig_q, dig_d;
    logic [7:0]              blocks_q, blocks_d;
    logic [DATA_W-1:0]       rdata_q, rdata_d, status;
    logic                    last_flag_q, last_flag_d, done_q, done_d, err_q, err_d;
    logic                    rd_ack_q, rd_ack_d, blk_valid_q, blk_valid_d, blk_last_q, blk_last_d;
    logic                    wr, rd, start, clr, busy, is_msg, is_dig, is_stat, is_ctl;

    assign rise    = ctrl_q & ~prev_q;
    assign wr      = rise[0];
    assign rd      = rise[1];
    assign start   = rise[2];
    assign clr     = rise[3];
    assign busy    = (state_q == SEND) || (state_q == WAIT);
    assign is_msg  = pio_addr < ADDR_W'(16);
    assign is_dig  = (pio_addr >= ADDR_W'(16)) && (pio_addr <= ADDR_W'(20));
    assign is_stat = pio_addr == ADDR_W'(32);
    assign is_ctl  = pio_addr == ADDR_W'(33);
    assign status  = DATA_W'({blocks_q, 5'd0, err_q, done_q, busy});

    assign pio_rdata    = rdata_q;
    assign pio_ctrl_out = {err_q, rd_ack_q, done_q, busy};
    assign blk_valid    = blk_valid_q;
    assign blk_last     = blk_last_q;
    assign blk_data     = msg_q;

    always_comb begin
        state_d     = state_q;
        msg_d       = msg_q;
        dig_d       = dig_q;
        blocks_d    = blocks_q;
        rdata_d     = rdata_q;
        last_flag_d = last_flag_q;
        done_d      = done_q;
        err_d       = err_q;
        rd_ack_d    = rd_ack_q;
        blk_valid_d = blk_valid_q;
        blk_last_d  = blk_last_q;
        if (wr) begin
            if (is_msg && !busy) msg_d[4'd15 - pio_addr[3:0]] = pio_wdata;
            if (is_ctl) last_flag_d = pio_wdata[0];
            if (!(is_msg || is_ctl) || (is_msg && busy)) err_d = 1'b1;
        end
        if (rd) begin
            rd_ack_d = ~rd_ack_q;
            rdata_d  = is_msg  ? msg_q[4'd15 - pio_addr[3:0]] :
                       is_dig  ? dig_q[3'd4 - pio_addr[2:0]] :
                       is_stat ? status : DATA_W'(32'hDEADBEEF);
            if (!(is_msg || is_dig || is_stat)) err_d = 1'b1;
        end
        case (state_q)
            IDLE, DONE: if (start) begin
                blk_valid_d = 1'b1;
                blk_last_d  = last_flag_q;
                state_d     = SEND;
                if (state_q == DONE) begin
                    done_d   = 1'b0;
                    blocks_d = 8'd0;
                end
            end
            SEND: if (blk_valid_q && blk_ready) begin
                blk_valid_d = 1'b0;
                blocks_d    = blocks_q + 8'd1;
                state_d     = blk_last_q ? WAIT : IDLE;
            end
            WAIT: if (dig_valid) begin
                dig_d   = dig_data;
                done_d  = 1'b1;
                state_d = DONE;
            end
        endcase
        if (start && busy) err_d = 1'b1;
        // clear outranks a simultaneous start; buffer and digest survive it
        if (clr) begin
            state_d     = IDLE;
            blk_valid_d = 1'b0;
            done_d      = 1'b0;
            err_d       = 1'b0;
            blocks_d    = 8'd0;
            last_flag_d = 1'b0;
        end
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            state_q     <= IDLE;
            ctrl_q      <= '0;
            prev_q      <= '0;
            msg_q       <= '0;
            dig_q       <= '0;
            blocks_q    <= '0;
            rdata_q     <= '0;
            last_flag_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rd_ack_q    <= 1'b0;
            blk_valid_q <= 1'b0;
            blk_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ctrl_q      <= pio_ctrl_in;
            prev_q      <= ctrl_q;
            msg_q       <= msg_d;
            dig_q       <= dig_d;
            blocks_q    <= blocks_d;
            rdata_q     <= rdata_d;
            last_flag_q <= last_flag_d;
            done_q      <= done_d;
            err_q       <= err_d;
            rd_ack_q    <= rd_ack_d;
            blk_valid_q <= blk_valid_d;
            blk_last_q  <= blk_last_d;
        end
    end
endmodule

// File: tb/tb_wpa2_pio_bridge.sv
// tb_wpa2_pio_bridge: randomized scoreboard bench for the PIO-to-SHA-1 register bridge
module tb_wpa2_pio_bridge;
    logic         clk_clk = 1'b0;
    logic         reset_reset_n = 1'b0;
    logic [7:0]   pio_addr = '0;
    logic [31:0]  pio_wdata = '0;
    logic [31:0]  pio_rdata;
    logic [3:0]   pio_ctrl_in = '0;
    logic [3:0]   pio_ctrl_out;
    logic         blk_valid, blk_last;
    logic         blk_ready = 1'b0;
    logic [511:0] blk_data;
    logic         dig_valid = 1'b0;
    logic [159:0] dig_data = '0;

    wpa2_pio_bridge #(.ADDR_W(8), .DATA_W(32)) dut (
        .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
        .pio_addr(pio_addr), .pio_wdata(pio_wdata), .pio_rdata(pio_rdata),
        .pio_ctrl_in(pio_ctrl_in), .pio_ctrl_out(pio_ctrl_out),
        .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_last(blk_last), .blk_data(blk_data),
        .dig_valid(dig_valid), .dig_data(dig_data)
    );

    always #5 clk_clk = ~clk_clk;

    int errors = 0;
    int checks = 0;

    // Reference model: register contents plus where the current message stands
    logic [31:0]  m_msg [16];
    logic [31:0]  m_dig [5];
    logic [7:0]   m_blocks = '0;
    bit           m_offered = 0, m_waiting = 0, m_done = 0, m_err = 0, m_last = 0, m_cur_last = 0;
    logic [31:0]  rd_q [$];
    logic [512:0] blk_q [$];

    task automatic check(input string name, input logic [519:0] got, input logic [519:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic bit m_busy();
        return m_offered | m_waiting;
    endfunction

    function automatic logic [511:0] m_block();
        logic [511:0] r = '0;
        for (int i = 0; i < 16; i++) r = {r[479:0], m_msg[i]};
        return r;
    endfunction

    function automatic logic [31:0] exp_read(input int a);
        if (a < 16) return m_msg[a];
        if (a <= 20) return m_dig[a-16];
        if (a == 32) return {16'h0, m_blocks, 5'h0, m_err, m_done, m_busy()};
        return 32'hDEADBEEF;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_msg[i] = '0;
        for (int i = 0; i < 5; i++) m_dig[i] = '0;
        m_blocks = '0; m_offered = 0; m_waiting = 0; m_done = 0; m_err = 0; m_last = 0; m_cur_last = 0;
    endtask

    // Monitor: every rd_ack toggle and every accepted block is matched against the queues
    logic prev_ack = 1'b0;
    always @(negedge clk_clk) begin
        #1;
        if (!reset_reset_n) prev_ack = 1'b0;
        else begin
            if (pio_ctrl_out[2] !== prev_ack) begin
                prev_ack = pio_ctrl_out[2];
                if (rd_q.size() == 0) begin
                    errors++; checks++;
                    $display("FAIL rd_unexpected: got rdata %0h with no read pending", pio_rdata);
                end else check("rdata", pio_rdata, rd_q.pop_front());
            end
            if (blk_valid && blk_ready) begin
                if (blk_q.size() == 0) begin
                    errors++; checks++;
                    $display("FAIL blk_unexpected: got block with no start pending");
                end else check("blk", {blk_last, blk_data}, blk_q.pop_front());
            end
        end
    end

    task automatic chk_status();
        check("status", {pio_ctrl_out[3], pio_ctrl_out[1], pio_ctrl_out[0]}, {m_err, m_done, m_busy()});
    endtask

    task automatic strobe(input int b, input logic [7:0] a, input logic [31:0] d);
        @(negedge clk_clk);
        pio_addr = a; pio_wdata = d; pio_ctrl_in[b] = 1'b1;
        repeat (3) @(negedge clk_clk);
        pio_ctrl_in[b] = 1'b0;
        repeat (2) @(negedge clk_clk);
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        if (a < 16) begin
            if (m_busy()) m_err = 1; else m_msg[a] = d;
        end else if (a == 33) m_last = d[0];
        else m_err = 1;
        strobe(0, 8'(a), d);
        chk_status();
    endtask

    task automatic rd(input int a);
        rd_q.push_back(exp_read(a));
        if (a > 20 && a != 32) m_err = 1;
        strobe(1, 8'(a), '0);
        chk_status();
    endtask

    task automatic start();
        bit was_busy = m_busy();
        if (was_busy) m_err = 1;
        else begin
            if (m_done) begin m_done = 0; m_blocks = '0; end
            m_offered = 1; m_cur_last = m_last;
            blk_q.push_back({m_last, m_block()});
        end
        @(negedge clk_clk);
        pio_ctrl_in[2] = 1'b1;
        @(negedge clk_clk); #1;
        if (!was_busy) check("blk_valid_early", blk_valid, 0);
        @(negedge clk_clk); #1;
        if (!was_busy) check("blk_offer", {blk_valid, blk_last, blk_data[511:480]}, {1'b1, m_cur_last, m_msg[0]});
        @(negedge clk_clk);
        pio_ctrl_in[2] = 1'b0;
        repeat (2) @(negedge clk_clk);
        chk_status();
    endtask

    task automatic accept(input int hold);
        logic [511:0] d0 = blk_data;
        repeat (hold) begin
            @(negedge clk_clk); #1;
            if (m_offered) check("blk_hold", {blk_valid, blk_data}, {1'b1, d0});
        end
        @(negedge clk_clk);
        blk_ready = 1'b1;
        @(negedge clk_clk);
        blk_ready = 1'b0;
        if (m_offered) begin
            m_offered = 0; m_blocks = m_blocks + 8'd1;
            if (m_cur_last) m_waiting = 1;
        end
        #1 check("blk_valid_drop", blk_valid, 0);
        chk_status();
    endtask

    task automatic digest(input logic [159:0] d);
        @(negedge clk_clk);
        dig_valid = 1'b1; dig_data = d;
        @(negedge clk_clk);
        dig_valid = 1'b0;
        if (m_waiting) begin
            for (int i = 0; i < 5; i++) m_dig[i] = d[159-32*i -: 32];
            m_done = 1; m_waiting = 0;
        end
        #1 check("done_latency", pio_ctrl_out[1], m_done);
        chk_status();
    endtask

    task automatic clear(input bit with_start);
        if (m_offered) void'(blk_q.pop_back());
        m_offered = 0; m_waiting = 0; m_done = 0; m_err = 0; m_blocks = '0; m_last = 0;
        @(negedge clk_clk);
        pio_ctrl_in[3] = 1'b1;
        pio_ctrl_in[2] = with_start;
        repeat (2) @(negedge clk_clk);
        #1 check("clear_blk_valid", blk_valid, 0);
        @(negedge clk_clk);
        pio_ctrl_in[3:2] = 2'b00;
        repeat (2) @(negedge clk_clk);
        #1 check("clear_blk_valid_late", blk_valid, 0);
        chk_status();
    endtask

    task automatic do_reset();
        @(negedge clk_clk);
        reset_reset_n = 1'b0;
        @(negedge clk_clk); #1;
        check("reset_outputs", {pio_rdata, pio_ctrl_out, blk_valid, blk_last, blk_data}, '0);
        repeat (2) @(negedge clk_clk);
        reset_reset_n = 1'b1;
        model_reset();
        blk_q.delete();
        #1 chk_status();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        model_reset();
        repeat (3) @(negedge clk_clk);
        #1 check("reset_outputs", {pio_rdata, pio_ctrl_out, blk_valid, blk_last}, '0);
        reset_reset_n = 1'b1;
        rd(32);
        // Single-block SHA-1("abc")
        wr(0, 32'h61626380);
        wr(15, 32'h00000018);
        wr(33, 1);
        start();
        accept(3);
        digest(160'hA9993E364706816ABA3E25717850C26C9CD0D89D);
        for (int a = 16; a <= 20; a++) rd(a);
        // Two-block message
        wr(33, 0);
        for (int i = 0; i < 16; i++) wr(i, $urandom);
        start();
        accept(1);
        rd(32);
        wr(3, $urandom);
        rd(3);
        wr(33, 1);
        start();
        accept(2);
        rd(32);
        digest({$urandom, $urandom, $urandom, $urandom, $urandom});
        for (int a = 16; a <= 20; a++) rd(a);
        // Illegal accesses while a block is pending, then clear mid-handshake
        start();
        wr(5, $urandom);
        rd(5);
        start();
        rd(8'h30);
        clear(0);
        clear(1);
        // blocks_sent wraps 255 -> 0
        for (int i = 0; i < 255; i++) begin
            start();
            accept(0);
        end
        rd(32);
        start();
        accept(0);
        rd(32);
        // Random traffic
        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 6))
                0, 1: wr($urandom_range(0, 47), $urandom);
                2, 3: rd($urandom_range(0, 47));
                4: start();
                5: accept($urandom_range(0, 3));
                default: if ($urandom_range(0, 3) == 0) clear(0);
                         else digest({$urandom, $urandom, $urandom, $urandom, $urandom});
            endcase
        end
        // Reset while waiting for the digest
        clear(0);
        wr(0, $urandom);
        wr(33, 1);
        start();
        accept(0);
        do_reset();
        rd(32);
        rd(0);
        rd(16);
        repeat (5) @(negedge clk_clk);
        check("rd_queue_drained", rd_q.size(), 0);
        check("blk_queue_drained", blk_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/wpa2_pio_bridge.md
# wpa2_pio_bridge

Fabric-side register bridge between the WPA2 soft-processor system's PIO conduits and the SHA-1 block engine. It decodes the CPU's level-driven strobes and address and write-data PIOs into register writes and reads. It assembles 512-bit message blocks in a local 16-word buffer, hands each block to the engine through a valid/ready handshake, and captures the returned 160-bit digest for readback on the read-data PIO.

## Interface
Parameters:
- ADDR_W, 8, PIO address width
- DATA_W, 32, PIO data width; fixed at 32, other values unsupported

Ports:
- clk_clk  in  1  system clock, shared with the processor system
- reset_reset_n  in  1  synchronous, active-low reset
- pio_addr  in  8  register address from the address PIO
- pio_wdata  in  32  write data from the write PIO
- pio_rdata  out  32  read data to the read PIO
- pio_ctrl_in  in  4  CPU strobes: [0] wr, [1] rd, [2] start, [3] clear
- pio_ctrl_out  out  4  status: [0] busy, [1] done, [2] rd_ack, [3] err
- blk_valid  out  1  message block offered to the engine
- blk_ready  in  1  engine accepts block
- blk_last  out  1  block is the final block of the message
- blk_data  out  512  W0 in [511:480] down to W15 in [31:0]
- dig_valid  in  1  one-cycle pulse, digest available
- dig_data  in  160  H0 in [159:128] down to H4 in [31:0]

## Operation
Strobes:
- All ctrl_in bits are levels held by software. Each bit is registered once, and a rising edge equals current & ~previous. One action is taken per rising edge.

Address map:
- 0x00–0x0F: message words W0–W15, read/write.
- 0x10–0x14: digest H0–H4, read-only.
- 0x20: status, read-only. [0] busy, [1] done, [2] err, [15:8] blocks sent.
- 0x21: control, write-only. Bit 0 is last_flag for the next start.

Register access:
- wr edge to an unmapped or read-only address sets err. No other state changes.
- wr edge to W0–W15 while busy sets err, and the buffer is unchanged.
- rd edge latches the addressed word into pio_rdata and toggles rd_ack. Unmapped reads return 0xDEADBEEF and set err.

State machine: IDLE, SEND, WAIT, DONE.
- IDLE: a start edge asserts blk_valid with blk_last = last_flag, then goes to SEND.
- SEND: hold blk_valid, blk_data and blk_last stable until blk_valid & blk_ready. Then increment blocks_sent (8-bit, wraps 255→0). If blk_last, go to WAIT; otherwise go to IDLE so software can load the next block.
- WAIT: on dig_valid, capture dig_data into H0–H4, set done, go to DONE.
- DONE: a start edge clears done, sets blocks_sent to 0 and starts a new message (goes to SEND).
- busy = state is SEND or WAIT.
- start edge while busy: ignored, sets err.
- clear edge in any state: go to IDLE, deassert blk_valid, clear done, err, blocks_sent and last_flag. Buffer and digest contents are kept.
- dig_valid outside WAIT: ignored. The digest registers are unchanged.
- clear and start edges in the same cycle: clear wins and start is dropped.

Reset values:
- pio_rdata = 0, pio_ctrl_out = 0, blk_valid = 0, blk_last = 0.
- Buffer, digest, blocks_sent and last_flag = 0.
- State = IDLE.
- Previous-strobe registers = 0, so a strobe held high through reset produces one edge after release.

## Timing
- Edge detect: a strobe sampled high at edge N, where it was low at N−1, acts at edge N+1.
- Write latency: the register is updated 2 cycles after the strobe rises.
- Read latency: pio_rdata is valid and rd_ack toggles 2 cycles after the rd strobe rises. pio_rdata holds until the next rd edge.
- Start to blk_valid: 2 cycles.
- Handshake: blk_valid deasserts on the cycle after acceptance. blk_data is not modified while blk_valid is high.
- dig_valid to done visible on pio_ctrl_out[1]: 1 cycle.
- Reset sampled low on any edge: all registers take reset values on that edge, including mid-handshake, where blk_valid drops immediately.

## Test plan
- Reset, then read 0x20: pio_rdata = 0x00000000 and pio_ctrl_out = 0.
- Write W0 = 0x61626380, W15 = 0x00000018, others 0. Write 0x21 = 1, then start. blk_data[511:480] = 0x61626380, blk_last = 1, and blk_valid holds for 3 cycles with blk_ready low. Then pulse dig_valid with the SHA-1("abc") digest. Reading 0x10–0x14 returns A9993E36, 4706816A, BA3E2571, 7850C26C, 9CD0D89D, and done = 1.
- Two-block message: start with last_flag = 0, state returns to IDLE and blocks_sent = 1. Write to W3 succeeds. Start with last_flag = 1, and blocks_sent reads 2 after acceptance.
- Write to W5 while in SEND: err = 1 and W5 is unchanged. Read 0x30: returns 0xDEADBEEF and err = 1.
- Clear edge during SEND: blk_valid is low 2 cycles after the strobe rises, state is IDLE and err = 0. Hold reset low during WAIT: all outputs read 0 on the next edge.
